// File: rtl/matmul_if.sv
// Signal bundle for the matmul datapath: the 4x4 binary16 matrix a, the
// 4-element column vector b and the registered result vector x.
// The producer side (master) drives a/b and observes x; the matmul side
// (slave) consumes a/b and drives x. There is no handshake.
interface matmul_if;
  logic [15:0][15:0] a;
  logic [3:0][15:0]  b;
  logic [3:0][15:0]  x;

  modport master (output a, output b, input x);
  modport slave  (input a, input b, output x);
endinterface

// File: rtl/matmul.sv
// 4x4 binary16 matrix times 4-element vector, x[r] = sum_c a[4r+c]*b[c].
// Each row forms four products and then sums them as (p0+p1)+(p2+p3).
// Every multiply and add is rounded to nearest-even. Subnormal inputs read
// as signed zero, subnormal results flush to signed zero, overflow
// saturates to signed infinity, and every NaN case yields 0x7E00.
// Configuration macro: MATMUL_PIPELINE_EN
//   defined   -> products, partial sums and x are registered (latency 3)
//   undefined -> products and sums are combinational into x (latency 1)
// Both builds produce bit-identical results.
module matmul (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0][15:0] a,
  input  logic [3:0][15:0]  b,
  output logic [3:0][15:0]  x
);

  localparam logic [15:0] QNAN = 16'h7E00;

  // Rounds an 11-bit significand (leading one included) with its guard and
  // sticky bits, then packs it, saturating or flushing out-of-range results.
  function automatic logic [15:0] round_pack(input logic s,
                                             input logic signed [7:0] e,
                                             input logic [10:0] m,
                                             input logic g,
                                             input logic st);
    logic [11:0]       mr;
    logic signed [7:0] er;
    mr = {1'b0, m} + {11'd0, (g & (st | m[0]))};
    er = e;
    if (mr[11]) begin
      mr = mr >> 1;
      er = er + 8'sd1;
    end
    if (er > 8'sd30) return {s, 15'h7C00};
    if (er < 8'sd1)  return {s, 15'h0000};
    return {s, er[4:0], mr[9:0]};
  endfunction

  // binary16 multiply.
  function automatic logic [15:0] fp_mul(input logic [15:0] p, input logic [15:0] q);
    logic              s;
    logic [4:0]        pe, qe;
    logic [9:0]        pm, qm;
    logic              p_nan, q_nan, p_inf, q_inf, p_zero, q_zero;
    logic [21:0]       sig;
    logic signed [7:0] e;
    s      = p[15] ^ q[15];
    pe     = p[14:10];
    qe     = q[14:10];
    pm     = p[9:0];
    qm     = q[9:0];
    p_nan  = (pe == 5'h1F) && (pm != 10'd0);
    q_nan  = (qe == 5'h1F) && (qm != 10'd0);
    p_inf  = (pe == 5'h1F) && (pm == 10'd0);
    q_inf  = (qe == 5'h1F) && (qm == 10'd0);
    p_zero = (pe == 5'd0);
    q_zero = (qe == 5'd0);
    sig    = 22'({1'b1, pm}) * 22'({1'b1, qm});
    e      = $signed({3'b000, pe}) + $signed({3'b000, qe}) - 8'sd15;
    if (p_nan || q_nan || (p_inf && q_zero) || (q_inf && p_zero)) return QNAN;
    if (p_inf || q_inf)   return {s, 15'h7C00};
    if (p_zero || q_zero) return {s, 15'h0000};
    if (sig[21]) return round_pack(s, e + 8'sd1, sig[21:11], sig[10], |sig[9:0]);
    return round_pack(s, e, sig[20:10], sig[9], |sig[8:0]);
  endfunction

  // binary16 add.
  function automatic logic [15:0] fp_add(input logic [15:0] p, input logic [15:0] q);
    logic [4:0]        pe, qe;
    logic              p_nan, q_nan, p_inf, q_inf, p_zero, q_zero;
    logic [15:0]       big, sml;
    logic [4:0]        d;
    logic [34:0]       big_sig, sml_full, sml_sig;
    logic              lost;
    logic [35:0]       sum, norm;
    logic [5:0]        lead;
    logic signed [7:0] e;
    pe     = p[14:10];
    qe     = q[14:10];
    p_nan  = (pe == 5'h1F) && (p[9:0] != 10'd0);
    q_nan  = (qe == 5'h1F) && (q[9:0] != 10'd0);
    p_inf  = (pe == 5'h1F) && (p[9:0] == 10'd0);
    q_inf  = (qe == 5'h1F) && (q[9:0] == 10'd0);
    p_zero = (pe == 5'd0);
    q_zero = (qe == 5'd0);
    if (p_nan || q_nan || (p_inf && q_inf && (p[15] != q[15]))) return QNAN;
    if (p_inf)            return {p[15], 15'h7C00};
    if (q_inf)            return {q[15], 15'h7C00};
    if (p_zero && q_zero) return {p[15] & q[15], 15'h0000};
    if (p_zero)           return q;
    if (q_zero)           return p;
    // Larger magnitude first, so the difference below is never negative.
    if (p[14:0] >= q[14:0]) begin
      big = p;
      sml = q;
    end else begin
      big = q;
      sml = p;
    end
    d        = big[14:10] - sml[14:10];
    big_sig  = {1'b1, big[9:0], 24'd0};
    sml_full = {1'b1, sml[9:0], 24'd0};
    sml_sig  = sml_full >> d;
    // Bits shifted past the bottom survive as a sticky one far below the
    // rounding point, enough to keep the guard/sticky decision exact.
    lost       = ((sml_sig << d) != sml_full);
    sml_sig[0] = sml_sig[0] | lost;
    if (big[15] == sml[15]) sum = {1'b0, big_sig} + {1'b0, sml_sig};
    else                    sum = {1'b0, big_sig} - {1'b0, sml_sig};
    if (sum == 36'd0) return 16'h0000;
    lead = 6'd0;
    for (int i = 0; i < 36; i++) begin
      if (sum[i]) lead = 6'(i);
    end
    norm = sum << (6'd35 - lead);
    e    = $signed({3'b000, big[14:10]}) + $signed({2'b00, lead}) - 8'sd34;
    return round_pack(big[15], e, norm[35:25], norm[24], |norm[23:0]);
  endfunction

  logic [15:0][15:0] prod_c;
  logic [7:0][15:0]  psum_c;
  logic [3:0][15:0]  sum_c;

  // Sixteen products of the current inputs, row-major.
  always_comb begin
    prod_c = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        prod_c[4*r+c] = fp_mul(a[4*r+c], b[c]);
      end
    end
  end

`ifdef MATMUL_PIPELINE_EN
  logic [15:0][15:0] prod_q;
  logic [7:0][15:0]  psum_q;

  // Stage 1: register products; reset clears any in-flight data.
  // NOTE: these datapath registers are reset on purpose, so stale operands
  // never reach x after reset and the fill cycles output exact zeros.
  always_ff @(posedge clk) begin
    if (rst) prod_q <= '0;
    else     prod_q <= prod_c;
  end

  // Partial sums (p0+p1) and (p2+p3) for each row from stage-1 products.
  always_comb begin
    psum_c = '0;
    for (int r = 0; r < 4; r++) begin
      psum_c[2*r]   = fp_add(prod_q[4*r],   prod_q[4*r+1]);
      psum_c[2*r+1] = fp_add(prod_q[4*r+2], prod_q[4*r+3]);
    end
  end

  // Stage 2: register partial sums.
  always_ff @(posedge clk) begin
    if (rst) psum_q <= '0;
    else     psum_q <= psum_c;
  end

  // Final row sums from stage-2 partial sums.
  always_comb begin
    sum_c = '0;
    for (int r = 0; r < 4; r++) begin
      sum_c[r] = fp_add(psum_q[2*r], psum_q[2*r+1]);
    end
  end
`else
  // Partial sums (p0+p1) and (p2+p3) for each row, straight from products.
  always_comb begin
    psum_c = '0;
    for (int r = 0; r < 4; r++) begin
      psum_c[2*r]   = fp_add(prod_c[4*r],   prod_c[4*r+1]);
      psum_c[2*r+1] = fp_add(prod_c[4*r+2], prod_c[4*r+3]);
    end
  end

  // Final row sums from the combinational partial sums.
  always_comb begin
    sum_c = '0;
    for (int r = 0; r < 4; r++) begin
      sum_c[r] = fp_add(psum_c[2*r], psum_c[2*r+1]);
    end
  end
`endif

  // Output register: final stage in both builds.
  // NOTE: state registers use non-blocking assignment so every register
  // samples pre-edge values and the pipeline shifts by exactly one stage.
  always_ff @(posedge clk) begin
    if (rst) x <= '0;
    else     x <= sum_c;
  end

endmodule

// File: tb/tb_matmul.sv
// Self-checking bench for matmul. Expected values come from fixed vectors
// and from a real-arithmetic reference model of the binary16 rules.
// Honours MATMUL_PIPELINE_EN to pick the expected latency.
module tb_matmul;

`ifdef MATMUL_PIPELINE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  matmul_if bus ();

  matmul dut (
    .clk (clk),
    .rst (rst),
    .a   (bus.a),
    .b   (bus.b),
    .x   (bus.x)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- comparison helpers ----------------
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [3:0][15:0] exp);
    for (int r = 0; r < 4; r++) begin
      check($sformatf("%s x[%0d]", tag, r), bus.x[r], exp[r]);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit h_nan(input logic [15:0] h);
    return (h[14:10] == 5'h1F) && (h[9:0] != 10'd0);
  endfunction
  function automatic bit h_inf(input logic [15:0] h);
    return (h[14:10] == 5'h1F) && (h[9:0] == 10'd0);
  endfunction
  function automatic bit h_zero(input logic [15:0] h);
    return (h[14:10] == 5'd0);
  endfunction

  function automatic real pow2(input int n);
    real v;
    v = 1.0;
    for (int i = 0; i < n; i++)  v = v * 2.0;
    for (int i = 0; i < -n; i++) v = v / 2.0;
    return v;
  endfunction

  // Signed real value of a finite binary16, subnormals read as zero.
  function automatic real h2r(input logic [15:0] h);
    real m;
    if (h_zero(h)) return 0.0;
    m = (1024.0 + real'(h[9:0])) / 1024.0 * pow2(int'(h[14:10]) - 15);
    return h[15] ? -m : m;
  endfunction

  // Round a non-zero real to binary16, nearest-even, with flush/saturate.
  function automatic logic [15:0] r2h(input real v);
    bit  neg;
    real s, fr;
    int  e, f;
    neg = (v < 0.0);
    s   = neg ? -v : v;
    e   = 0;
    while (s >= 2.0) begin s = s / 2.0; e++; end
    while (s < 1.0)  begin s = s * 2.0; e--; end
    s  = s * 1024.0;
    f  = $rtoi(s);
    fr = s - real'(f);
    if (fr > 0.5 || (fr == 0.5 && (f % 2) == 1)) f++;
    if (f == 2048) begin f = 1024; e++; end
    if (e > 15)  return {neg, 15'h7C00};
    if (e < -14) return {neg, 15'h0000};
    return {neg, 5'(e + 15), 10'(f - 1024)};
  endfunction

  function automatic logic [15:0] ref_mul(input logic [15:0] p, input logic [15:0] q);
    bit s;
    s = p[15] ^ q[15];
    if (h_nan(p) || h_nan(q)) return 16'h7E00;
    if ((h_inf(p) && h_zero(q)) || (h_inf(q) && h_zero(p))) return 16'h7E00;
    if (h_inf(p) || h_inf(q))   return {s, 15'h7C00};
    if (h_zero(p) || h_zero(q)) return {s, 15'h0000};
    return r2h(h2r(p) * h2r(q));
  endfunction

  function automatic logic [15:0] ref_add(input logic [15:0] p, input logic [15:0] q);
    real v;
    if (h_nan(p) || h_nan(q)) return 16'h7E00;
    if (h_inf(p) && h_inf(q)) return (p[15] == q[15]) ? p : 16'h7E00;
    if (h_inf(p)) return p;
    if (h_inf(q)) return q;
    if (h_zero(p) && h_zero(q)) return {p[15] & q[15], 15'h0000};
    v = h2r(p) + h2r(q);
    if (v == 0.0) return 16'h0000;
    return r2h(v);
  endfunction

  function automatic logic [3:0][15:0] ref_matvec(input logic [15:0][15:0] ma,
                                                  input logic [3:0][15:0]  vb);
    logic [3:0][15:0] res;
    logic [15:0]      pr [4];
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) pr[c] = ref_mul(ma[4*r+c], vb[c]);
      res[r] = ref_add(ref_add(pr[0], pr[1]), ref_add(pr[2], pr[3]));
    end
    return res;
  endfunction

  function automatic logic [15:0] rand_half();
    logic [15:0] specials [7];
    specials = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E00, 16'h0001, 16'h7BFF};
    case ($urandom_range(0, 9))
      0:       return 16'($urandom);
      1:       return specials[$urandom_range(0, 6)];
      default: return {1'($urandom), 5'($urandom_range(8, 22)), 10'($urandom)};
    endcase
  endfunction

  // ---------------- stimulus ----------------
  logic [15:0][15:0] a24, a23, a_mix;
  logic [3:0][15:0]  b24, b23, exp_v;
  logic [3:0][15:0]  exp_q [$];
  logic [15:0][15:0] ra;
  logic [3:0][15:0]  rb;

  task automatic wait_latency();
    repeat (LAT) @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [15:0][15:0] va, input logic [3:0][15:0] vb);
    @(negedge clk);
    bus.a = va;
    bus.b = vb;
  endtask

  initial begin
    a24 = '0; a24[0] = 16'h3C00; a24[1] = 16'h4000;
    b24 = '0; b24[0] = 16'h3C00; b24[1] = 16'h3800; b24[2] = 16'h4000; b24[3] = 16'h3C00;
    a23 = '0; a23[15] = 16'h3C00;
    b23 = '0; b23[3] = 16'h3C00;

    // Reset with live, non-zero stimulus: x must stay cleared.
    rst   = 1'b1;
    bus.a = a24;
    bus.b = b24;
    repeat (LAT + 2) @(posedge clk);
    #1;
    check_vec("reset", 64'h0);

    // Release reset: pipeline fill outputs zero, then 2.0 exactly at latency.
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("fill%0d x[0]", k), bus.x[0], 16'h0000);
    end
    @(posedge clk);
    #1;
    check_vec("mixed row", {16'h0000, 16'h0000, 16'h0000, 16'h4000});

    // Identity row.
    apply(a23, b23);
    wait_latency();
    check_vec("identity", {16'h3C00, 16'h0000, 16'h0000, 16'h0000});

    // Exact cancellation gives +0.
    a_mix = '0; a_mix[4] = 16'h3C00; a_mix[5] = 16'hBC00;
    exp_v = '0; exp_v[0] = 16'h3C00; exp_v[1] = 16'h3C00;
    apply(a_mix, exp_v);
    wait_latency();
    check_vec("cancel", 64'h0);

    // Overflow to +inf, then to -inf.
    a_mix = '0; a_mix[8] = 16'h7BFF;
    exp_v = '0; exp_v[0] = 16'h4000;
    apply(a_mix, exp_v);
    wait_latency();
    check("overflow x[2]", bus.x[2], 16'h7C00);
    a_mix[8] = 16'hFBFF;
    apply(a_mix, exp_v);
    wait_latency();
    check("neg overflow x[2]", bus.x[2], 16'hFC00);

    // inf * 0 -> canonical NaN.
    a_mix = '0; a_mix[8] = 16'h7C00;
    apply(a_mix, 64'h0);
    wait_latency();
    check("inf*0 x[2]", bus.x[2], 16'h7E00);

    // Subnormal input reads as zero, so inf * subnormal is also NaN.
    a_mix = '0; a_mix[0] = 16'h0001;
    exp_v = '0; exp_v[0] = 16'h7C00;
    apply(a_mix, exp_v);
    wait_latency();
    check("inf*subnormal x[0]", bus.x[0], 16'h7E00);

    // All four products -0 -> -0; a single -0 among +0s -> +0.
    a_mix = '0; a_mix[0] = 16'h8000; a_mix[1] = 16'h8000; a_mix[2] = 16'h8000; a_mix[3] = 16'h8000;
    a_mix[4] = 16'h8000;
    exp_v = {16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00};
    apply(a_mix, exp_v);
    wait_latency();
    check("all -0 x[0]", bus.x[0], 16'h8000);
    check("one -0 x[1]", bus.x[1], 16'h0000);

    // Reset mid-operation with stimulus held.
    apply(a24, b24);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_vec("mid reset", 64'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("refill%0d x[0]", k), bus.x[0], 16'h0000);
    end
    @(posedge clk);
    #1;
    check("after reset x[0]", bus.x[0], 16'h4000);

    // Back-to-back streaming: alternate the identity and mixed patterns.
    a_mix = a24;
    a_mix[15] = 16'h3C00;
    exp_q.delete();
    for (int i = 0; i < 12 + LAT; i++) begin
      @(negedge clk);
      if (i >= LAT) check_vec($sformatf("stream%0d", i - LAT), exp_q.pop_front());
      if (i < 12) begin
        bus.a = a_mix;
        bus.b = (i % 2 == 0) ? b23 : b24;
        exp_q.push_back(ref_matvec(a_mix, bus.b));
      end
    end

    // Randomized streaming against the reference model.
    exp_q.delete();
    for (int i = 0; i < 200 + LAT; i++) begin
      @(negedge clk);
      if (i >= LAT) check_vec($sformatf("rand%0d", i - LAT), exp_q.pop_front());
      if (i < 200) begin
        for (int k = 0; k < 16; k++) ra[k] = rand_half();
        for (int k = 0; k < 4; k++)  rb[k] = rand_half();
        bus.a = ra;
        bus.b = rb;
        exp_q.push_back(ref_matvec(ra, rb));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matmul.md
MATMUL -- requirements
Module: matmul

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: a  input  16x16 (packed [15:0][15:0])  4x4 matrix of IEEE-754 binary16; element (row r, col c) = a[4r+c].
REQ-004 SHALL have port: b  input  4x16 (packed [3:0][15:0])  4-element binary16 column vector; b[c] = element c.
REQ-005 SHALL have port: x  output  4x16 (packed [3:0][15:0])  binary16 result vector, registered.
REQ-006 SHALL have no parameters; all widths fixed as above.

Function
REQ-007 SHALL compute x[r] = sum over c=0..3 of a[4r+c]*b[c], for r=0..3, every clock, fully pipelined (new a/b accepted each cycle, no handshake).
REQ-008 SHALL form four products per row, then sum as (p0+p1)+(p2+p3), each multiply and add individually rounded.
REQ-009 SHALL round every operation to nearest, ties to even.
REQ-010 SHALL treat subnormal inputs as signed zero and flush subnormal results to signed zero.
REQ-011 SHALL saturate overflow to signed infinity (0x7C00 / 0xFC00).
REQ-012 SHALL output canonical NaN 0x7E00 for any NaN operand, inf*0, or inf+(-inf).
REQ-013 SHALL return +0 (0x0000) for exact cancellation and for +0 + -0; -0 only when both addends are -0.
REQ-014 SHALL give product sign = XOR of operand signs, including zero and infinity results.
REQ-015 SHALL hold x constant between updates; x changes only on a rising clk edge.

Reset
REQ-016 SHALL, while rst=1 at a rising edge, clear x[0..3] to 0x0000 and clear every pipeline register to 0x0000.
REQ-017 SHALL discard all in-flight results on reset; the first non-zero x after rst deasserts reflects inputs sampled on or after the first edge with rst=0.
REQ-018 SHALL, after rst deasserts, drive x from the pipeline at the normal latency; cycles before the pipeline fills output 0x0000.

Configuration
REQ-019 SHALL use macro MATMUL_PIPELINE_EN to select pipeline depth.
REQ-020 SHALL, with MATMUL_PIPELINE_EN defined, register products (stage 1), partial sums (stage 2) and final sums into x (stage 3): latency 3 cycles from the sampling edge of a/b to x.
REQ-021 SHALL, without MATMUL_PIPELINE_EN, compute all products and sums combinationally into the x register: latency 1 cycle.
REQ-022 SHALL produce bit-identical x values in both configurations; only latency differs.

Verification
REQ-023 SHALL pass identity row: a[15]=0x3C00, a[12..14]=0, b[3]=0x3C00 -> x[3]=0x3C00 after latency.
REQ-024 SHALL pass mixed row: a[0..3]={0x3C00,0x4000,0,0}, b={0x3C00,0x3800,0x4000,0x3C00} -> x[0]=0x4000 (2.0).
REQ-025 SHALL pass cancellation: a[4..7]={0x3C00,0xBC00,0,0}, b[0]=b[1]=0x3C00 -> x[1]=0x0000.
REQ-026 SHALL pass specials: a[8]=0x7BFF, b[0]=0x4000, rest of row 2 zero -> x[2]=0x7C00; a[8]=0x7C00, b[0]=0x0000 -> x[2]=0x7E00.
REQ-027 SHALL pass reset mid-operation: apply REQ-024 stimulus, assert rst one cycle later for one cycle -> x=0x0000 on that edge; x[0]=0x4000 reappears exactly one latency after rst deasserts with stimulus held.
REQ-028 SHALL pass back-to-back streaming: change b every cycle (REQ-023/REQ-024 patterns alternating) -> x follows the same sequence delayed by the configured latency, no lost or duplicated results.
